baud_rate_controller: RTL and testbench
=======================================

# baud_rate_controller

Configuration sequencer for the UART baud-rate generator: accepts a rate-change request over a req/ack handshake and looks up the 12-bit divisor for the selected rate. It waits until the serial line is between characters, then loads the new `baud_value` while holding the generator in reset so its phase restarts cleanly. Sits between the host/register interface and `baudrate_generator`, and is the only driver of the generator's `baud_value` and reset inputs.

## Interface
- `CLK_FREQ`, 50_000_000: system clock frequency in Hz; used only to compute divisors.
- `RESET_SEL`, 2: rate code loaded at reset (57600 baud).
- `SETTLE_CYCLES`, 4: cycles the generator is held in reset after a new divisor is loaded (≥1).
- `TIMEOUT_CYCLES`, 1_000_000: maximum cycles to wait for `line_busy` low before aborting (≥1).

- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  one clock; reset is synchronous and active-high.
- `req`  in  1  rate-change request; accepted only when `ready`=1.
- `rate_sel`  in  3  requested rate code; sampled on the accepting edge.
- `line_busy`  in  1  high while UART TX or RX is mid-character.
- `ready`  out  1  high in IDLE only.
- `ack`  out  1  one-cycle pulse: change applied.
- `nack`  out  1  one-cycle pulse: request rejected (reserved code or timeout).
- `cur_sel`  out  3  rate code currently applied.
- `baud_value`  out  12  divisor to generator.
- `gen_reset`  out  1  generator reset, active-low (0 = hold generator in reset).

## Operation
- Rate table, divisor = round(CLK_FREQ/rate) − 1. At 50 MHz: 0: 19200→2603, 1: 38400→1301, 2: 57600→867, 3: 115200→433, 4: 230400→216, 5: 460800→108. Codes 6 and 7 are reserved.
- Divisors that exceed 4095 saturate to 4095. An elaboration-time check flags any saturated entry.
- FSM states: IDLE, WAIT_IDLE, HOLD, DONE.
- IDLE: `ready`=1. On `req`=1:
  - reserved code → `nack` next cycle; stay in IDLE.
  - `rate_sel`==`cur_sel` → `ack` next cycle; no generator reset.
  - otherwise latch the code and go to WAIT_IDLE.
- WAIT_IDLE: a timeout counter runs from 0.
  - On the first cycle with `line_busy`=0, go to HOLD.
  - If the counter reaches TIMEOUT_CYCLES first, pulse `nack`, go to IDLE, and leave the configuration unchanged.
- HOLD: on entry, `baud_value` and `cur_sel` update and `gen_reset`=0. Stays for exactly SETTLE_CYCLES cycles. `line_busy` is ignored here.
- DONE: `gen_reset`=1 and `ack`=1 for one cycle, then IDLE.
- `req` outside IDLE is ignored; it is not queued. `rate_sel` changes after acceptance have no effect.
- `ack` and `nack` are never high together.

## Timing
- All outputs are registered.
- Values on the cycle after `reset` is sampled high:
  - state IDLE, `ready`=1, `ack`=`nack`=0
  - `cur_sel`=RESET_SEL, `baud_value`=divisor(RESET_SEL)
  - `gen_reset`=0
- `gen_reset` returns to 1 on the first edge with `reset` low.
- Reset mid-sequence (any state) aborts immediately and restores the reset values; no `ack` or `nack` is issued.
- Latency, with acceptance at edge E and `line_busy`=0:
  - WAIT_IDLE at E+1, HOLD at E+2.
  - `gen_reset`=0 during E+2 … E+1+SETTLE_CYCLES.
  - `ack` high for the cycle starting at E+2+SETTLE_CYCLES.
  - IDLE (`ready`=1) at E+3+SETTLE_CYCLES.
- Reject or same-code response: `nack` or `ack` is high for the cycle after E, and `ready` stays 1.
- A timeout counter value of TIMEOUT_CYCLES−1 with `line_busy` still 1 → `nack` on the next edge. `line_busy` falling on that same edge takes priority: the change proceeds.

## Structure
- Package `baud_pkg` holds:
  - rate code constants (`BAUD_19200` … `BAUD_460800`)
  - the rate-in-Hz table
  - the divisor function `baud_div(clk_freq, code)` with saturation
  - the FSM state enum
  - the 12-bit divisor width constant
- Sub-module `baud_cycle_timer`: a loadable down-counter with a `zero` flag, shared by the HOLD settle count and the WAIT_IDLE timeout.

## Test plan
- Reset then release: `cur_sel`=2, `baud_value`=867, `gen_reset`=0 during reset and 1 after, `ready`=1.
- `req` with `rate_sel`=3, `line_busy`=0, SETTLE_CYCLES=4: `baud_value`=433 at E+2, `gen_reset` low for 4 cycles, `ack` at E+6, `cur_sel`=3.
- `line_busy` high for 50 cycles after `req` with `rate_sel`=0: `baud_value` stays 867 until the cycle after `line_busy` falls, then 2603 and `ack`.
- TIMEOUT_CYCLES=100 with `line_busy` held high: `nack` exactly 100 cycles after WAIT_IDLE entry; `baud_value`, `cur_sel` and `gen_reset` unchanged.
- `rate_sel`=6 and `rate_sel`=7: `nack` next cycle, no state change. `rate_sel`=2 while `cur_sel`=2: `ack` next cycle, `gen_reset` stays 1.
- `reset` asserted during HOLD: outputs return to reset values next cycle, no `ack`, and a later `req` with `rate_sel`=5 yields `baud_value`=108.

Source files
------------

// File: rtl/baud_pkg.sv
// Shared definitions for the baud-rate configuration sequencer:
// rate codes, the rate table, divisor computation and FSM states.
package baud_pkg;

    localparam int unsigned BAUD_DIV_W = 32'd12;
    localparam int unsigned RATE_SEL_W = 32'd3;
    localparam int unsigned NUM_RATES  = 32'd6;

    localparam logic [RATE_SEL_W-1:0] BAUD_19200  = 3'd0;
    localparam logic [RATE_SEL_W-1:0] BAUD_38400  = 3'd1;
    localparam logic [RATE_SEL_W-1:0] BAUD_57600  = 3'd2;
    localparam logic [RATE_SEL_W-1:0] BAUD_115200 = 3'd3;
    localparam logic [RATE_SEL_W-1:0] BAUD_230400 = 3'd4;
    localparam logic [RATE_SEL_W-1:0] BAUD_460800 = 3'd5;

    localparam logic [BAUD_DIV_W-1:0] BAUD_DIV_MAX = 12'hFFF;

    // Codes 6 and 7 are reserved and carry a zero rate.
    localparam int unsigned BAUD_RATE_HZ [0:7] = '{
        32'd19200, 32'd38400, 32'd57600, 32'd115200,
        32'd230400, 32'd460800, 32'd0, 32'd0
    };

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_IDLE = 2'd1,
        HOLD      = 2'd2,
        DONE      = 2'd3
    } baud_state_e;

    function automatic logic is_reserved(input logic [RATE_SEL_W-1:0] code);
        return (code > BAUD_460800);
    endfunction

    // round(clk_freq / rate) - 1 before saturation
    function automatic longint unsigned baud_div_raw(input int unsigned clk_freq,
                                                     input logic [RATE_SEL_W-1:0] code);
        longint unsigned rate;
        longint unsigned quot;
        rate = 64'(BAUD_RATE_HZ[code]);
        if (rate != 64'd0) begin
            quot = (64'(clk_freq) + (rate >> 1)) / rate;
        end else begin
            quot = 64'd0;
        end
        return (quot == 64'd0) ? 64'd0 : (quot - 64'd1);
    endfunction

    function automatic logic baud_div_saturates(input int unsigned clk_freq,
                                                input logic [RATE_SEL_W-1:0] code);
        return (baud_div_raw(clk_freq, code) > 64'(BAUD_DIV_MAX));
    endfunction

    function automatic logic [BAUD_DIV_W-1:0] baud_div(input int unsigned clk_freq,
                                                       input logic [RATE_SEL_W-1:0] code);
        return baud_div_saturates(clk_freq, code) ? BAUD_DIV_MAX
                                                  : BAUD_DIV_W'(baud_div_raw(clk_freq, code));
    endfunction

endpackage

// File: rtl/baud_cycle_timer.sv
// Loadable down-counter with a registered zero flag; reused for the
// line-idle timeout and the generator settle hold.
module baud_cycle_timer #(
    parameter int unsigned WIDTH = 32'd8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             en,
    output logic             zero
);

    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] count_next_s;
    logic             zero_r;

    // Next count: load wins, otherwise decrement and stick at zero.
    always_comb begin
        count_next_s = count_r;
        if (load) begin
            count_next_s = load_value;
        end else if (en && (count_r != {WIDTH{1'b0}})) begin
            count_next_s = count_r - WIDTH'(1);
        end else begin
            count_next_s = count_r;
        end
    end

    // Counter and zero flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= {WIDTH{1'b0}};
            zero_r  <= 1'b1;
        end else begin
            count_r <= count_next_s;
            zero_r  <= (count_next_s == {WIDTH{1'b0}});
        end
    end

    assign zero = zero_r;

endmodule

// File: rtl/baud_rate_controller.sv
// Rate-change sequencer for the UART baud generator: validates a request,
// waits for a gap between characters, then loads the divisor under reset.
module baud_rate_controller
    import baud_pkg::*;
#(
    parameter int unsigned CLK_FREQ       = 32'd50_000_000,
    parameter int unsigned RESET_SEL      = 32'd2,
    parameter int unsigned SETTLE_CYCLES  = 32'd4,
    parameter int unsigned TIMEOUT_CYCLES = 32'd1_000_000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    input  logic [RATE_SEL_W-1:0] rate_sel,
    input  logic                  line_busy,
    output logic                  ready,
    output logic                  ack,
    output logic                  nack,
    output logic [RATE_SEL_W-1:0] cur_sel,
    output logic [BAUD_DIV_W-1:0] baud_value,
    output logic                  gen_reset
);

    localparam logic [RATE_SEL_W-1:0] RESET_CODE = RATE_SEL_W'(RESET_SEL);
    localparam logic [BAUD_DIV_W-1:0] RESET_DIV  = baud_div(CLK_FREQ, RESET_CODE);
    localparam int unsigned TMR_MAX = (TIMEOUT_CYCLES > SETTLE_CYCLES) ? TIMEOUT_CYCLES
                                                                        : SETTLE_CYCLES;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 32'd1);
    localparam logic [TMR_W-1:0] TIMEOUT_LOAD = TMR_W'(TIMEOUT_CYCLES - 32'd1);
    localparam logic [TMR_W-1:0] SETTLE_LOAD  = TMR_W'(SETTLE_CYCLES - 32'd1);

    logic [BAUD_DIV_W-1:0] div_table_s [8];

    // Divisors are elaboration constants; a saturated entry is a configuration error.
    for (genvar g = 0; g < 8; g++) begin : g_div_table
        assign div_table_s[g] = baud_div(CLK_FREQ, RATE_SEL_W'(g));
        if ((g < NUM_RATES) && baud_div_saturates(CLK_FREQ, RATE_SEL_W'(g))) begin : g_sat
            $error("baud_rate_controller: divisor for rate code %0d saturates at 4095", g);
        end
    end

    baud_state_e           state_r;
    baud_state_e           next_state_s;
    logic [RATE_SEL_W-1:0] pend_sel_r;
    logic [RATE_SEL_W-1:0] pend_sel_next_s;
    logic                  ready_r;
    logic                  ack_r;
    logic                  nack_r;
    logic                  gen_reset_r;
    logic [RATE_SEL_W-1:0] cur_sel_r;
    logic [BAUD_DIV_W-1:0] baud_value_r;
    logic                  ack_s;
    logic                  nack_s;
    logic                  gen_reset_s;
    logic                  apply_s;
    logic                  tmr_load_s;
    logic                  tmr_en_s;
    logic                  tmr_zero_s;
    logic [TMR_W-1:0]      tmr_load_val_s;

    baud_cycle_timer #(
        .WIDTH(TMR_W)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .load      (tmr_load_s),
        .load_value(tmr_load_val_s),
        .en        (tmr_en_s),
        .zero      (tmr_zero_s)
    );

    // Next-state and next-output decode.
    always_comb begin
        next_state_s    = state_r;
        pend_sel_next_s = pend_sel_r;
        ack_s           = 1'b0;
        nack_s          = 1'b0;
        gen_reset_s     = 1'b1;
        apply_s         = 1'b0;
        tmr_load_s      = 1'b0;
        tmr_load_val_s  = TIMEOUT_LOAD;
        tmr_en_s        = 1'b0;
        case (state_r)
            IDLE: begin
                if (req) begin
                    if (is_reserved(rate_sel)) begin
                        nack_s = 1'b1;
                    end else if (rate_sel == cur_sel_r) begin
                        ack_s = 1'b1;
                    end else begin
                        pend_sel_next_s = rate_sel;
                        tmr_load_s      = 1'b1;
                        tmr_load_val_s  = TIMEOUT_LOAD;
                        next_state_s    = WAIT_IDLE;
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            WAIT_IDLE: begin
                // A quiet line on the final timeout cycle still wins over the abort.
                if (!line_busy) begin
                    apply_s        = 1'b1;
                    gen_reset_s    = 1'b0;
                    tmr_load_s     = 1'b1;
                    tmr_load_val_s = SETTLE_LOAD;
                    next_state_s   = HOLD;
                end else if (tmr_zero_s) begin
                    nack_s       = 1'b1;
                    next_state_s = IDLE;
                end else begin
                    tmr_en_s = 1'b1;
                end
            end
            HOLD: begin
                if (tmr_zero_s) begin
                    ack_s        = 1'b1;
                    next_state_s = DONE;
                end else begin
                    gen_reset_s = 1'b0;
                    tmr_en_s    = 1'b1;
                end
            end
            DONE: begin
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // FSM state and pending rate code.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            pend_sel_r <= RESET_CODE;
        end else begin
            state_r    <= next_state_s;
            pend_sel_r <= pend_sel_next_s;
        end
    end

    // Registered outputs and applied configuration.
    always_ff @(posedge clk) begin
        if (reset) begin
            ready_r      <= 1'b1;
            ack_r        <= 1'b0;
            nack_r       <= 1'b0;
            gen_reset_r  <= 1'b0;
            cur_sel_r    <= RESET_CODE;
            baud_value_r <= RESET_DIV;
        end else begin
            ready_r     <= (next_state_s == IDLE);
            ack_r       <= ack_s;
            nack_r      <= nack_s;
            gen_reset_r <= gen_reset_s;
            if (apply_s) begin
                cur_sel_r    <= pend_sel_r;
                baud_value_r <= div_table_s[pend_sel_r];
            end else begin
                cur_sel_r    <= cur_sel_r;
                baud_value_r <= baud_value_r;
            end
        end
    end

    assign ready      = ready_r;
    assign ack        = ack_r;
    assign nack       = nack_r;
    assign gen_reset  = gen_reset_r;
    assign cur_sel    = cur_sel_r;
    assign baud_value = baud_value_r;

endmodule

// File: tb/tb_baud_rate_controller.sv
// Self-checking bench for baud_rate_controller: directed scenarios then
// randomized requests against a transaction-level timing model.
module tb_baud_rate_controller;

    localparam int unsigned SETTLE  = 4;
    localparam int unsigned TMO     = 100;
    localparam logic [2:0]  RST_SEL = 3'd2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic [2:0]  rate_sel;
    logic        line_busy;
    logic        ready;
    logic        ack;
    logic        nack;
    logic [2:0]  cur_sel;
    logic [11:0] baud_value;
    logic        gen_reset;

    int tests_run    = 0;
    int tests_failed = 0;

    // Expected divisors at 50 MHz; reserved codes are never applied.
    int exp_div [8] = '{2603, 1301, 867, 433, 216, 108, 0, 0};
    logic [2:0] model_sel;

    baud_rate_controller #(
        .CLK_FREQ      (50_000_000),
        .RESET_SEL     (2),
        .SETTLE_CYCLES (SETTLE),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .rate_sel  (rate_sel),
        .line_busy (line_busy),
        .ready     (ready),
        .ack       (ack),
        .nack      (nack),
        .cur_sel   (cur_sel),
        .baud_value(baud_value),
        .gen_reset (gen_reset)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ctl = {ready, ack, nack, gen_reset}; cfg = {cur_sel, baud_value}
    task automatic check_outputs(input string tag, input logic e_ready, input logic e_ack,
                                 input logic e_nack, input logic e_gen, input logic [2:0] e_sel);
        check_eq({tag, ".ctl"}, {28'd0, ready, ack, nack, gen_reset},
                 {28'd0, e_ready, e_ack, e_nack, e_gen});
        check_eq({tag, ".cfg"}, {17'd0, cur_sel, baud_value},
                 {17'd0, e_sel, 12'(exp_div[e_sel])});
    endtask

    task automatic idle_cycles(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            req       = 1'b0;
            rate_sel  = 3'($urandom);
            line_busy = 1'($urandom);
            tick();
            check_outputs($sformatf("%s.idle%0d", name, i), 1'b1, 1'b0, 1'b0, 1'b1, model_sel);
        end
    endtask

    // One request from IDLE; line_busy held high for the first 'busy' cycles after acceptance.
    task automatic run_req(input string name, input logic [2:0] sel, input int busy);
        logic [2:0] old_sel;
        bit reserved_c;
        bit same_c;
        int h;
        int a;
        int last;
        old_sel    = model_sel;
        reserved_c = (sel > 3'd5);
        same_c     = !reserved_c && (sel == model_sel);
        req        = 1'b1;
        rate_sel   = sel;
        line_busy  = 1'($urandom);
        tick();
        if (reserved_c || same_c) begin
            check_outputs($sformatf("%s.resp", name), 1'b1, same_c, reserved_c, 1'b1, old_sel);
            req = 1'b0;
        end else begin
            h = 2 + busy;
            a = h + int'(SETTLE);
            last = (busy >= int'(TMO)) ? int'(TMO) + 1 : a + 1;
            for (int k = 1; k <= last; k++) begin
                if (k > 1) begin
                    tick();
                end
                if (busy >= int'(TMO)) begin
                    check_outputs($sformatf("%s.k%0d", name, k), k == last, 1'b0, k == last,
                                  1'b1, old_sel);
                end else begin
                    check_outputs($sformatf("%s.k%0d", name, k), k == last, k == a, 1'b0,
                                  !(k >= h && k < a), (k >= h) ? sel : old_sel);
                end
                req       = (k < last) ? 1'($urandom) : 1'b0;
                rate_sel  = 3'($urandom);
                line_busy = (k <= busy);
            end
            if (busy < int'(TMO)) begin
                model_sel = sel;
            end
        end
    endtask

    initial begin
        logic [2:0] sel;
        int busy;
        reset     = 1'b1;
        req       = 1'b0;
        rate_sel  = 3'd0;
        line_busy = 1'b0;
        model_sel = RST_SEL;

        for (int i = 0; i < 3; i++) begin
            tick();
            check_outputs($sformatf("reset%0d", i), 1'b1, 1'b0, 1'b0, 1'b0, RST_SEL);
        end
        reset = 1'b0;
        tick();
        check_outputs("release", 1'b1, 1'b0, 1'b0, 1'b1, RST_SEL);

        run_req("same2", 3'd2, 0);
        idle_cycles("same2", 1);
        run_req("rsv6", 3'd6, 0);
        run_req("rsv7", 3'd7, 0);
        idle_cycles("rsv", 2);
        run_req("busy50", 3'd0, 50);
        run_req("chg3", 3'd3, 0);
        run_req("tmo100", 3'd1, int'(TMO));
        idle_cycles("tmo", 2);
        run_req("edge99", 3'd4, int'(TMO) - 1);

        // Reset lands while the generator is held for a change to code 1.
        req       = 1'b1;
        rate_sel  = 3'd1;
        line_busy = 1'b0;
        tick();
        check_outputs("rsthold.wait", 1'b0, 1'b0, 1'b0, 1'b1, 3'd4);
        req = 1'b0;
        tick();
        check_outputs("rsthold.entry", 1'b0, 1'b0, 1'b0, 1'b0, 3'd1);
        tick();
        check_outputs("rsthold.hold", 1'b0, 1'b0, 1'b0, 1'b0, 3'd1);
        reset = 1'b1;
        tick();
        check_outputs("rsthold.reset", 1'b1, 1'b0, 1'b0, 1'b0, RST_SEL);
        reset     = 1'b0;
        model_sel = RST_SEL;
        idle_cycles("rsthold.after", int'(SETTLE) + 3);
        run_req("after_rst5", 3'd5, 0);

        for (int n = 0; n < 40; n++) begin
            sel = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 4) == 0) begin
                sel = model_sel;
            end
            case ($urandom_range(0, 5))
                0:       busy = 0;
                1, 2:    busy = int'($urandom_range(1, 12));
                3:       busy = int'(TMO) - 1;
                4:       busy = int'(TMO);
                default: busy = int'(TMO) + int'($urandom_range(1, 20));
            endcase
            run_req($sformatf("rand%0d", n), sel, busy);
            idle_cycles($sformatf("rand%0d", n), int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
